sram_param: RTL and testbench

Parametrised single-port synchronous SRAM: the next generation of the lab's 64K×32 `SRAM`. Adds configurable data/address width, per-byte write enables, a configurable read pipeline (1–3 cycles) with a read-valid strobe, and a hardware clear engine that zeroes the array after reset. It is the backing store for core instruction/data memories and for any block needing a deterministic-content RAM.

---
 rtl/sram_param.sv | 120 ++++++++++++
 tb/tb_sram_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_param.sv
`timescale 1ns/1ps
// Parametrised single-port synchronous SRAM with byte enables, a 1..3 cycle
// read pipeline with valid strobe, and a post-reset clear engine.
module sram_param #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   di,
  output logic [DATA_W-1:0]   dout,
  output logic                rvalid,
  output logic                busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if ((DATA_W == 0) || (DATA_W % 8 != 0)) begin : g_bad_data_w
    $error("sram_param: DATA_W must be a non-zero multiple of 8");
  end
  if ((READ_LAT < 1) || (READ_LAT > 3)) begin : g_bad_read_lat
    $error("sram_param: READ_LAT must be 1, 2 or 3");
  end

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                rd_req, wr_req;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [READ_LAT-1:0] vld_q;
  logic [DATA_W-1:0]   data_q [READ_LAT];

  assign busy = (state_q == S_CLEAR);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        // Pointer wraps back to 0 on the final increment, leaving it ready for the next clear.
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        rd_req = en & ~we;
        wr_req = en & we;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array content is never reset; only the clear engine and byte writes touch it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr_q] <= '0;
    end else if (wr_req) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= di[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 samples the array at the request edge; later stages only load on a
  // valid beat so the last stage holds the previous result between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < READ_LAT; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= rd_req;
      if (rd_req) begin
        data_q[0] <= mem[addr];
      end
      for (int unsigned s = 1; s < READ_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          data_q[s] <= data_q[s-1];
        end
      end
    end
  end

  assign dout   = data_q[READ_LAT-1];
  assign rvalid = vld_q[READ_LAT-1];

endmodule

// File: tb/tb_sram_param.sv
`timescale 1ns/1ps
// Directed bench for sram_param: clear engine, busy rejection, byte enables,
// read pipeline ordering/latency, and asynchronous reset mid-clear and mid-read.
module tb_sram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n;
  int rv;

  // A: ADDR_W=4, READ_LAT=3, clear on reset
  logic        rst_a, en_a, we_a, rvalid_a, busy_a;
  logic [3:0]  be_a, addr_a;
  logic [31:0] di_a, dout_a;
  // B: defaults, READ_LAT=1, no clear
  logic        rst_b, en_b, we_b, rvalid_b, busy_b;
  logic [3:0]  be_b;
  logic [15:0] addr_b;
  logic [31:0] di_b, dout_b;
  // C: ADDR_W=4, READ_LAT=2, clear on reset
  logic        rst_c, en_c, we_c, rvalid_c, busy_c;
  logic [3:0]  be_c, addr_c;
  logic [31:0] di_c, dout_c;

  sram_param #(.DATA_W(32), .ADDR_W(4), .READ_LAT(3), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .reset_n(rst_a), .en(en_a), .we(we_a), .be(be_a), .addr(addr_a),
    .di(di_a), .dout(dout_a), .rvalid(rvalid_a), .busy(busy_a));

  sram_param #(.DATA_W(32), .ADDR_W(16), .READ_LAT(1), .CLEAR_ON_RESET(1'b0)) u_b (
    .clk(clk), .reset_n(rst_b), .en(en_b), .we(we_b), .be(be_b), .addr(addr_b),
    .di(di_b), .dout(dout_b), .rvalid(rvalid_b), .busy(busy_b));

  sram_param #(.DATA_W(32), .ADDR_W(4), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)) u_c (
    .clk(clk), .reset_n(rst_c), .en(en_c), .we(we_c), .be(be_c), .addr(addr_c),
    .di(di_c), .dout(dout_c), .rvalid(rvalid_c), .busy(busy_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    en_a = 1'b1; we_a = 1'b1; addr_a = a; di_a = d; be_a = b;
    tick();
    en_a = 1'b0; we_a = 1'b0;
  endtask

  task automatic wr_b(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
    en_b = 1'b1; we_b = 1'b1; addr_b = a; di_b = d; be_b = b;
    tick();
    en_b = 1'b0; we_b = 1'b0;
  endtask

  task automatic wr_c(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    en_c = 1'b1; we_c = 1'b1; addr_c = a; di_c = d; be_c = b;
    tick();
    en_c = 1'b0; we_c = 1'b0;
  endtask

  function automatic logic [15:0] baddr(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    if (k < 16) return kk;
    else if (k == 16) return 16'h8000;
    else return 16'hFFFF;
  endfunction

  function automatic logic [31:0] bdat(input logic [15:0] a);
    return {~a, a};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; en_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; di_a = '0;
    rst_b = 1'b0; en_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; di_b = '0;
    rst_c = 1'b0; en_c = 1'b0; we_c = 1'b0; be_c = '0; addr_c = '0; di_c = '0;
    repeat (3) tick();
    chk("rst_busy_a", {31'd0, busy_a}, 32'd1);
    chk("rst_dout_a", dout_a, 32'd0);
    chk("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    chk("rst_dout_b", dout_b, 32'd0);
    chk("rst_busy_c", {31'd0, busy_c}, 32'd1);

    // A: clear length, write at clear cycle 5 and read at cycle 8 must be ignored
    rst_a = 1'b1;
    n = 0; rv = 0;
    while (busy_a === 1'b1 && n < 40) begin
      en_a = (n == 4) || (n == 7); we_a = (n == 4);
      addr_a = 4'd3; di_a = 32'h0000_DEAD; be_a = 4'hF;
      tick();
      n++;
      if (rvalid_a === 1'b1) rv++;
    end
    en_a = 1'b0; we_a = 1'b0;
    chk("clear_cycles_a", n, 32'd16);
    chk("clear_no_rvalid_a", rv, 32'd0);

    for (int k = 0; k < 18; k++) begin
      en_a = (k < 16); we_a = 1'b0; addr_a = k[3:0];
      tick();
      if (k >= 2) begin
        chk("clr_read_rvalid_a", {31'd0, rvalid_a}, 32'd1);
        chk("clr_read_dout_a", dout_a, 32'd0);
      end else begin
        chk("clr_read_lat_a", {31'd0, rvalid_a}, 32'd0);
      end
    end
    en_a = 1'b0;
    tick();
    chk("clr_read_end_a", {31'd0, rvalid_a}, 32'd0);

    // A: byte enables
    wr_a(4'd5, 32'hAABB_CCDD, 4'hF);
    wr_a(4'd5, 32'h1122_3344, 4'b0101);
    wr_a(4'd1, 32'h10, 4'hF);
    wr_a(4'd2, 32'h20, 4'hF);
    wr_a(4'd3, 32'h30, 4'hF);
    en_a = 1'b1; we_a = 1'b0; addr_a = 4'd5;
    tick();
    en_a = 1'b0;
    chk("be_lat0_a", {31'd0, rvalid_a}, 32'd0);
    tick();
    chk("be_lat1_a", {31'd0, rvalid_a}, 32'd0);
    tick();
    chk("be_rvalid_a", {31'd0, rvalid_a}, 32'd1);
    chk("be_dout_a", dout_a, 32'hAA22_CC44);
    tick();
    chk("be_strobe_a", {31'd0, rvalid_a}, 32'd0);
    chk("be_hold_a", dout_a, 32'hAA22_CC44);

    // A: back-to-back reads 1,2,3
    for (int k = 0; k < 6; k++) begin
      en_a = (k < 3); we_a = 1'b0; addr_a = 4'(k + 1);
      tick();
      if (k < 2) begin
        chk("b2b_lat_a", {31'd0, rvalid_a}, 32'd0);
      end else if (k < 5) begin
        chk("b2b_rvalid_a", {31'd0, rvalid_a}, 32'd1);
        chk("b2b_dout_a", dout_a, 32'(16 * (k - 1)));
      end else begin
        chk("b2b_end_a", {31'd0, rvalid_a}, 32'd0);
        chk("b2b_hold_a", dout_a, 32'h30);
      end
    end
    en_a = 1'b0;

    // A: read then write same address, then read back new value
    en_a = 1'b1; we_a = 1'b0; addr_a = 4'd2;
    tick();
    we_a = 1'b1; di_a = 32'h99; be_a = 4'hF;
    tick();
    we_a = 1'b0;
    tick();
    en_a = 1'b0;
    chk("rw_old_rvalid_a", {31'd0, rvalid_a}, 32'd1);
    chk("rw_old_dout_a", dout_a, 32'h20);
    tick();
    chk("rw_gap_a", {31'd0, rvalid_a}, 32'd0);
    tick();
    chk("wr_new_rvalid_a", {31'd0, rvalid_a}, 32'd1);
    chk("wr_new_dout_a", dout_a, 32'h99);

    // B: legacy-style sweep with READ_LAT=1, no clear
    rst_b = 1'b1;
    for (int k = 0; k < 18; k++) wr_b(baddr(k), bdat(baddr(k)), 4'hF);
    wr_b(16'd7, 32'hFFFF_FFFF, 4'h0);
    wr_b(16'd8, 32'h1234_5678, 4'b1000);
    for (int k = 0; k < 18; k++) begin
      en_b = 1'b1; we_b = 1'b0; addr_b = baddr(k);
      tick();
      chk("sweep_rvalid_b", {31'd0, rvalid_b}, 32'd1);
      chk("sweep_dout_b", dout_b, (k == 8) ? 32'h12F7_0008 : bdat(baddr(k)));
    end
    en_b = 1'b0;
    tick();
    chk("sweep_end_b", {31'd0, rvalid_b}, 32'd0);
    chk("sweep_hold_b", dout_b, 32'h0000_FFFF);

    // C: reset with a read in flight, then reset mid-clear
    rst_c = 1'b1;
    n = 0;
    while (busy_c === 1'b1 && n < 40) begin tick(); n++; end
    chk("clear_cycles_c", n, 32'd16);
    wr_c(4'd0, 32'h5A, 4'hF);
    wr_c(4'd15, 32'hF0F0, 4'hF);
    en_c = 1'b1; we_c = 1'b0; addr_c = 4'd15;
    tick();
    en_c = 1'b0;
    chk("rd_lat_c", {31'd0, rvalid_c}, 32'd0);
    tick();
    chk("rd_rvalid_c", {31'd0, rvalid_c}, 32'd1);
    chk("rd_dout_c", dout_c, 32'hF0F0);
    en_c = 1'b1; addr_c = 4'd0;
    tick();
    en_c = 1'b0;
    chk("inflight_hold_c", dout_c, 32'hF0F0);
    rst_c = 1'b0;
    #1;
    chk("async_dout_c", dout_c, 32'd0);
    chk("async_rvalid_c", {31'd0, rvalid_c}, 32'd0);
    chk("async_busy_c", {31'd0, busy_c}, 32'd1);
    tick();
    chk("flushed_c", {31'd0, rvalid_c}, 32'd0);
    rst_c = 1'b1;
    repeat (8) tick();
    chk("midclear_busy_c", {31'd0, busy_c}, 32'd1);
    rst_c = 1'b0;
    #1;
    chk("midclear_rst_busy_c", {31'd0, busy_c}, 32'd1);
    tick();
    rst_c = 1'b1;
    n = 0;
    while (busy_c === 1'b1 && n < 40) begin tick(); n++; end
    chk("reclear_cycles_c", n, 32'd16);
    en_c = 1'b1; we_c = 1'b0; addr_c = 4'd0;
    tick();
    addr_c = 4'd15;
    chk("reclear_lat_c", {31'd0, rvalid_c}, 32'd0);
    tick();
    en_c = 1'b0;
    chk("reclear_rv0_c", {31'd0, rvalid_c}, 32'd1);
    chk("reclear_d0_c", dout_c, 32'd0);
    tick();
    chk("reclear_rv15_c", {31'd0, rvalid_c}, 32'd1);
    chk("reclear_d15_c", dout_c, 32'd0);
    tick();
    chk("reclear_end_c", {31'd0, rvalid_c}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
